// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   instr_types : decoded instruction record handed to IF/ID.
//   rv32i_types : architectural constants (reset PC, NOP encoding, alignment).
//   ctrl_types  : fetch controller state encoding.

package instr_types;

  // Field-split RV32I word plus every immediate format, pre-extended to 32 bits.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
  } instr_t;

endpackage

package rv32i_types;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0060;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

package ctrl_types;

  // REQ : request outstanding (or about to issue) at pc
  // HOLD: returned word parked while downstream stalls
  // DROP: request outstanding across a redirect; its response is thrown away
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_decode.sv
// Combinational RV32I field extraction and immediate sign-extension.

module instr_decode
  import instr_types::*;
(
  input  logic [31:0] word_i,
  output instr_t      instr_o
);

  assign instr_o = '{
    opcode: word_i[6:0],
    rd:     word_i[11:7],
    funct3: word_i[14:12],
    rs1:    word_i[19:15],
    rs2:    word_i[24:20],
    funct7: word_i[31:25],
    imm_i:  {{20{word_i[31]}}, word_i[31:20]},
    imm_s:  {{20{word_i[31]}}, word_i[31:25], word_i[11:7]},
    imm_b:  {{19{word_i[31]}}, word_i[31], word_i[7], word_i[30:25], word_i[11:8], 1'b0},
    imm_u:  {word_i[31:12], 12'b0},
    imm_j:  {{11{word_i[31]}}, word_i[31], word_i[19:12], word_i[20], word_i[30:21], 1'b0}
  };

endmodule

// File: rtl/if_fetch_stage_register.sv
// Generic loadable register with synchronous active-high reset.

module register #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Reset to RESET_VAL, otherwise capture d_i when load_i is set.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      q_o <= RESET_VAL;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register.
// Issues one read at a time, parks the returned word during stalls and
// squashes the in-flight response after a redirect.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.

module if_fetch_stage
  import instr_types::*, rv32i_types::*, ctrl_types::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] PC_STRIDE = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output instr_t      if_instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pc_load;
  logic [31:0]  target_q, target_d;
  logic         target_load;
  logic         valid_q, valid_d;
  logic [31:0]  word_q, word_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  redirect_tgt;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;

  register #(.WIDTH(32), .RESET_VAL(PC_RESET)) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  register #(.WIDTH(32), .RESET_VAL(PC_RESET)) u_target_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (target_load),
    .d_i    (target_d),
    .q_o    (target_q)
  );

  // Next-state logic: redirect outranks everything, then response, then stall.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_d        = pc_q + PC_STRIDE;
    target_load = 1'b0;
    target_d    = redirect_tgt;
    valid_d     = 1'b0;
    word_d      = NOP_WORD;
    if_pc_d     = if_pc_q;

    unique case (state_q)
      REQ: begin
        if (redirect) begin
          if (imem_resp) begin
            // Response lands with the redirect: drop it, refetch at once.
            pc_load = 1'b1;
            pc_d    = redirect_tgt;
          end else begin
            // Read still in flight: remember where to go once it returns.
            target_load = 1'b1;
            state_d     = DROP;
          end
        end else if (imem_resp) begin
          valid_d = 1'b1;
          word_d  = imem_rdata;
          if_pc_d = pc_q;
          if (stall) begin
            state_d = HOLD;
          end else begin
            pc_load = 1'b1;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (stall) begin
          valid_d = 1'b1;
          word_d  = word_q;
        end else begin
          pc_load = 1'b1;
          state_d = REQ;
        end
      end

      DROP: begin
        if (imem_resp) begin
          pc_load = 1'b1;
          pc_d    = redirect ? redirect_tgt : target_q;
          state_d = REQ;
        end else if (redirect) begin
          target_load = 1'b1;
        end
      end

      default: state_d = REQ;
    endcase
  end

  // State and presentation registers; bubbles carry a NOP word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      valid_q <= 1'b0;
      word_q  <= NOP_WORD;
      if_pc_q <= PC_RESET;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      if_pc_q <= if_pc_d;
    end
  end

  assign imem_read    = !rst && (state_q != HOLD);
  assign imem_address = pc_q;
  assign if_valid     = valid_q;
  assign if_pc        = if_pc_q;

  instr_decode u_decode (
    .word_i  (word_q),
    .instr_o (if_instruction)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        accept;
  logic        stall_cycle;
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  assign accept      = (state_q == REQ) && imem_resp && !redirect;
  assign stall_cycle = (state_q == HOLD) || ((state_q == REQ) && !imem_resp);

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall_cycle) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random
// stall/redirect/latency traffic against a transaction-level fetch model.

module tb_if_fetch_stage;
  import instr_types::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        if_valid;
  logic [31:0] if_pc;
  instr_t      if_instruction;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model of the fetch stream.
  logic [31:0] m_pc, m_tgt, m_word, m_ifpc;
  bit          m_held, m_squash, m_valid;
  logic [31:0] m_fetch, m_stalls;

  // Memory model: one outstanding read, fixed latency per request.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat = 2;

  // Observation logs for directed literal checks.
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pres_pc[$];
  instr_t      pres_ins[$];
  bit          prev_v;
  logic [31:0] prev_pc;
  int          hold_cycles;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    if (a == 32'h64) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Decode by arithmetic shifts/masks on the integer value of the word.
  function automatic instr_t tb_decode(input logic [31:0] w);
    instr_t r;
    int s, sign, top7;
    s    = $signed(w);
    sign = s >>> 31;
    top7 = s >>> 25;
    r.opcode = 7'(w % 128);
    r.rd     = 5'((w >> 7) % 32);
    r.funct3 = 3'((w >> 12) % 8);
    r.rs1    = 5'((w >> 15) % 32);
    r.rs2    = 5'((w >> 20) % 32);
    r.funct7 = 7'(w >> 25);
    r.imm_i  = s >>> 20;
    r.imm_s  = (top7 << 5) | ((w >> 7) & 31);
    r.imm_b  = (sign << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
    r.imm_u  = w & 32'hFFFF_F000;
    r.imm_j  = (sign << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_imem_read", imem_read, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h60);
    check("rst_if_instruction", if_instruction, tb_decode(32'h13));
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    m_pc = 32'h60; m_tgt = 32'h60; m_word = 32'h13; m_ifpc = 32'h60;
    m_held = 0; m_squash = 0; m_valid = 0; m_fetch = '0; m_stalls = '0;
    mem_busy = 0;
    req_log.delete(); req_cyc.delete(); pres_pc.delete(); pres_ins.delete();
    prev_v = 0; prev_pc = '0; hold_cycles = 0;
  endtask

  // One clock: compare outputs to the model, drive inputs, advance the model.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit          resp;
    bit          exp_read;
    logic [31:0] rdata;
    #1;
    exp_read = !m_held;
    check("imem_read", imem_read, exp_read);
    if (exp_read) check("imem_address", imem_address, m_pc);
    check("if_valid", if_valid, m_valid);
    if (m_valid) check("if_pc", if_pc, m_ifpc);
    check("if_instruction", if_instruction, tb_decode(m_word));
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("stall_cnt", stall_cnt, m_stalls);
`endif
    if (if_valid && !(prev_v && if_pc == prev_pc)) begin
      pres_pc.push_back(if_pc);
      pres_ins.push_back(if_instruction);
    end
    prev_v  = if_valid;
    prev_pc = if_pc;
    if (if_valid && !imem_read) hold_cycles++;

    if (!mem_busy && exp_read) begin
      mem_busy = 1; mem_addr = m_pc; mem_cnt = lat - 1;
      req_log.push_back(imem_address);
      req_cyc.push_back(cyc);
    end
    resp  = mem_busy && (mem_cnt == 0);
    rdata = resp ? mem_word(mem_addr) : $urandom;
    if (resp) mem_busy = 0;
    else if (mem_busy) mem_cnt--;

    stall = st; redirect = rd; redirect_pc = rpc;
    imem_resp = resp; imem_rdata = rdata;

    if (m_held) begin
      m_stalls++;
      if (rd) begin
        m_pc = align(rpc); m_held = 0; m_valid = 0; m_word = 32'h13;
      end else if (!st) begin
        m_pc = m_pc + 4; m_held = 0; m_valid = 0; m_word = 32'h13;
      end
    end else if (m_squash) begin
      m_valid = 0; m_word = 32'h13;
      if (resp) begin
        m_pc = rd ? align(rpc) : m_tgt;
        m_squash = 0;
      end else if (rd) begin
        m_tgt = align(rpc);
      end
    end else begin
      if (!resp) m_stalls++;
      if (rd) begin
        m_valid = 0; m_word = 32'h13;
        if (resp) m_pc = align(rpc);
        else begin m_squash = 1; m_tgt = align(rpc); end
      end else if (resp) begin
        m_valid = 1; m_word = rdata; m_ifpc = m_pc; m_fetch++;
        if (st) m_held = 1;
        else m_pc = m_pc + 4;
      end else begin
        m_valid = 0; m_word = 32'h13;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Sequential fetch, discarded response under redirect, redirect with
    // coincident response, then redirect+stall while holding.
    do_reset();
    lat = 2;
    repeat (4) step(0, 0, '0);
    lat = 3;
    step(0, 0, '0);                     // request to 0x68 issued
    step(0, 1, 32'h200);                // redirect while outstanding
    step(0, 0, '0);                     // stale 0x68 response arrives
    lat = 2;
    step(0, 0, '0);                     // request to 0x200
    step(0, 1, 32'h303);                // redirect with response
    step(0, 0, '0);                     // request to 0x300
    step(1, 0, '0);                     // response with stall -> hold
    step(1, 1, 32'h400);                // redirect + stall while holding
    step(0, 0, '0);
    step(0, 0, '0);
    check("seq_req0", req_log[0], 32'h60);
    check("seq_req1", req_log[1], 32'h64);
    check("seq_req2", req_log[2], 32'h68);
    check("redir_req", req_log[3], 32'h200);
    check("redir_resp_req", req_log[4], 32'h300);
    check("redir_resp_no_bubble", 32'(req_cyc[4] - req_cyc[3]), 32'd2);
    check("hold_redir_req", req_log[5], 32'h400);
    check("pres_count", 32'(pres_pc.size()), 32'd3);
    check("pres_pc0", pres_pc[0], 32'h60);
    check("pres_pc1", pres_pc[1], 32'h64);
    check("pres_pc2", pres_pc[2], 32'h300);
    check("pres0_opcode", 32'(pres_ins[0].opcode), 32'h13);
    check("pres1_rd", 32'(pres_ins[1].rd), 32'd1);
    check("pres1_imm_i", pres_ins[1].imm_i, 32'd1);

    // Response with a three-cycle stall.
    do_reset();
    lat = 2;
    step(0, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 0, '0);
    step(0, 0, '0);
    check("hold_cycles", 32'(hold_cycles), 32'd3);
    check("hold_pres_pc", pres_pc[0], 32'h60);
    check("hold_next_req", req_log[1], 32'h64);

    // PC wrap at the top of the address space, misaligned target.
    do_reset();
    lat = 2;
    step(0, 1, 32'hFFFF_FFFE);
    repeat (7) step(0, 0, '0);
    check("wrap_req_top", req_log[1], 32'hFFFF_FFFC);
    check("wrap_req_zero", req_log[2], 32'h0);
    check("wrap_pres_top", pres_pc[0], 32'hFFFF_FFFC);
    check("wrap_pres_zero", pres_pc[1], 32'h0);
`ifdef FETCH_PERF_CNT_EN
    #1;
    check("wrap_fetch_cnt", fetch_cnt, 32'd3);
`endif

    // Random traffic, with a reset dropped in mid-stream.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues single-word reads to the instruction memory/cache over a read/resp handshake.
- Holds a returned word while the pipeline is stalled and discards stale responses after a redirect.
- Presents a decoded instr_t plus its PC and a valid flag to the IF/ID register; the IF/ID load and flush controls are derived from if_valid.

Parameters:
- PC_RESET, 32'h0000_0060, fetch PC loaded on reset.
- PC_STRIDE, 4, bytes added to PC per sequential fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  downstream cannot accept; IF/ID not loading this cycle.
- redirect  in  1  taken branch/jump from EX; one-cycle pulse.
- redirect_pc  in  32  target PC, valid with redirect.
- imem_read  out  1  read request, held high until imem_resp.
- imem_address  out  32  word address of request, stable while imem_read.
- imem_rdata  in  32  returned instruction word, valid with imem_resp.
- imem_resp  in  1  one-cycle response strobe.
- if_valid  out  1  if_instruction/if_pc hold a real instruction.
- if_pc  out  32  PC of presented instruction.
- if_instruction  out  192  instr_types::instr_t decoded from the held word.

Behaviour:
- Reset: the FSM enters REQ; pc = PC_RESET; if_valid = 0; hold register = 32'h0000_0013 (NOP); if_pc = PC_RESET; imem_read = 0 in the reset cycle.
- FSM states: REQ, HOLD, DROP.
- REQ:
  - imem_read = 1; imem_address = pc.
  - On imem_resp with no redirect: latch rdata and pc into the hold register.
  - If stall = 0 in that same cycle: present it (if_valid = 1 the following cycle); pc += PC_STRIDE; stay in REQ.
  - If stall = 1 in that same cycle: go to HOLD.
- HOLD:
  - imem_read = 0; if_valid = 1; outputs frozen.
  - When stall = 0: pc += PC_STRIDE; return to REQ.
- DROP (request outstanding at redirect):
  - imem_read stays 1 with the old address until imem_resp.
  - The response is discarded; pc = saved redirect target; then go to REQ.
- Redirect:
  - Highest priority.
  - In REQ without imem_resp in the same cycle: save the target and go to DROP; if_valid = 0 next cycle.
  - In REQ with imem_resp in the same cycle: discard the response; pc = redirect_pc; stay in REQ.
  - In HOLD: drop the held instruction; pc = redirect_pc; go to REQ.
  - In DROP: overwrite the saved target.
- Redirect and stall together: redirect wins; if_valid = 0.
- Valid timing:
  - if_valid is registered and deasserts the cycle after a redirect or when no response arrived.
  - Bubbles present a NOP decode with if_valid = 0.
- Throughput:
  - Best case is one instruction per imem latency + 1 cycles; the next request issues the cycle after a response.
- PC arithmetic:
  - 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
  - redirect_pc[1:0] is forced to 0.
- Reset mid-request:
  - Any in-flight response is ignored; no imem_resp is expected after rst, so the block goes straight to REQ.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds output fetch_cnt (32) and output stall_cnt (32), both reset to 0.
  - fetch_cnt increments on each accepted (non-discarded) response.
  - stall_cnt increments each cycle in HOLD or in REQ with imem_read = 1 and no resp.
  - Both wrap at 2^32.
- When undefined, neither port nor logic exists; the stage is otherwise identical.

Decomposition:
- Package ctrl_types: typedef enum fetch_state_t {REQ, HOLD, DROP}.
- Package rv32i_types: constants PC_RESET_DEFAULT and NOP_WORD (32'h13).
- Sub-module instr_decode: combinational 32-bit word -> instr_types::instr_t, instantiated on the hold register.
- The pc/target registers reuse the existing register module.

Test Plan:
- Reset, then imem_resp with 2-cycle latency, words 0x00000013/0x00100093 -> imem_address 0x60, then 0x64; if_pc 0x60 then 0x64 with if_valid = 1.
- Response arrives with stall = 1 for 3 cycles -> HOLD; imem_read = 0; outputs stable 3 cycles; next request to 0x64 after stall drops.
- Redirect to 0x200 while a request to 0x68 is outstanding -> 0x68 response discarded (if_valid stays 0); next imem_address = 0x200.
- Redirect coincident with imem_resp -> response discarded; next request to redirect_pc with no extra bubble.
- Redirect and stall same cycle in HOLD -> held instruction dropped; if_valid = 0; fetch restarts at target.
- pc = 0xFFFFFFFC fetched -> next imem_address = 0x00000000; with FETCH_PERF_CNT_EN, fetch_cnt increments by exactly the accepted response count.
